// File: rtl/tdc_capture_ctrl_if.sv
// Control, status and BRAM port-B signals between the TDC capture controller and the GPIO/BRAM side.
// master = controller side; slave = GPIO/BRAM side.
interface tdc_capture_ctrl_if #(
  parameter int ONES_W = 8,
  parameter int ADDR_W = 15
) ();
  logic [ONES_W-1:0] ones;
  logic              run;
  logic              clr;
  logic              ring_mode;
  logic [7:0]        decim;
  logic              rdy;
  logic              full;
  logic              wrapped;
  logic [ADDR_W-1:0] wr_ptr;
  logic              clkb;
  logic              rstb;
  logic              enb;
  logic [3:0]        web;
  logic [ADDR_W-1:0] addrb;
  logic [31:0]       datab;

  modport master (
    input  ones, run, clr, ring_mode, decim,
    output rdy, full, wrapped, wr_ptr, clkb, rstb, enb, web, addrb, datab
  );

  modport slave (
    output ones, run, clr, ring_mode, decim,
    input  rdy, full, wrapped, wr_ptr, clkb, rstb, enb, web, addrb, datab
  );
endinterface

// File: rtl/tdc_capture_ctrl.sv
// Streams TDC hit counts into BRAM port B (one-shot or ring, decimated) and clears the buffer on command.
// All outputs registered: a write strobe decided in a cycle is visible one cycle later; no backpressure.
module tdc_capture_ctrl #(
  parameter int ONES_W = 8,
  parameter int ADDR_W = 15
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  tdc_capture_ctrl_if.master  bus
);

  typedef enum logic [2:0] {IDLE, RUN, RUN_DONE, CLEAR, CLR_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  state_t            state_q, state_d;
  logic              ring_q, ring_d;
  logic [7:0]        decim_q, decim_d;
  logic [7:0]        dcnt_q, dcnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wrapped_q, wrapped_d;
  logic              full_q, full_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              rdy_q, rdy_d;
  logic              enb_q, enb_d;
  logic [3:0]        web_q, web_d;
  logic [ADDR_W-1:0] addrb_q, addrb_d;
  logic [31:0]       datab_q, datab_d;

  always_comb begin
    state_d   = state_q;
    ring_d    = ring_q;
    decim_d   = decim_q;
    dcnt_d    = dcnt_q;
    ptr_d     = ptr_q;
    wrapped_d = wrapped_q;
    full_d    = full_q;
    wr_ptr_d  = wr_ptr_q;
    enb_d     = 1'b0;
    web_d     = 4'h0;
    addrb_d   = addrb_q;
    datab_d   = datab_q;
    rdy_d     = (state_q == IDLE);

    case (state_q)
      IDLE: begin
        addrb_d = '0;
        datab_d = '0;
        if (bus.clr) begin
          state_d   = CLEAR;
          ptr_d     = '0;
          wrapped_d = 1'b0;
          wr_ptr_d  = '0;
        end else if (bus.run) begin
          state_d   = RUN;
          ring_d    = bus.ring_mode;
          decim_d   = bus.decim;
          dcnt_d    = '0;
          ptr_d     = '0;
          wrapped_d = 1'b0;
          full_d    = 1'b0;
          wr_ptr_d  = '0;
        end
      end

      RUN: begin
        if (!bus.run) begin
          state_d = RUN_DONE;
        end else begin
          dcnt_d = (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
          if (dcnt_q == 8'd0) begin
            enb_d    = 1'b1;
            web_d    = 4'hF;
            datab_d  = 32'(bus.ones);
            addrb_d  = ptr_q;
            wr_ptr_d = ptr_q;
            ptr_d    = ptr_q + STEP;
            // The pointer wraps to 0 by natural overflow after LAST.
            if (ptr_q == LAST) begin
              if (ring_q) begin
                wrapped_d = 1'b1;
              end else begin
                state_d = RUN_DONE;
                full_d  = 1'b1;
              end
            end
          end
        end
      end

      RUN_DONE: begin
        datab_d = '0;
        if (!bus.run) state_d = IDLE;
      end

      CLEAR: begin
        enb_d   = 1'b1;
        web_d   = 4'hF;
        datab_d = '0;
        addrb_d = ptr_q;
        full_d  = 1'b1;
        ptr_d   = ptr_q + STEP;
        if (ptr_q == LAST) state_d = CLR_DONE;
      end

      CLR_DONE: begin
        full_d = 1'b0;
        if (!bus.clr) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      ring_q    <= 1'b0;
      decim_q   <= '0;
      dcnt_q    <= '0;
      ptr_q     <= '0;
      wrapped_q <= 1'b0;
      full_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rdy_q     <= 1'b0;
      enb_q     <= 1'b0;
      web_q     <= 4'h0;
      addrb_q   <= '0;
      datab_q   <= '0;
    end else begin
      state_q   <= state_d;
      ring_q    <= ring_d;
      decim_q   <= decim_d;
      dcnt_q    <= dcnt_d;
      ptr_q     <= ptr_d;
      wrapped_q <= wrapped_d;
      full_q    <= full_d;
      wr_ptr_q  <= wr_ptr_d;
      rdy_q     <= rdy_d;
      enb_q     <= enb_d;
      web_q     <= web_d;
      addrb_q   <= addrb_d;
      datab_q   <= datab_d;
    end
  end

  assign bus.rdy     = rdy_q;
  assign bus.full    = full_q;
  assign bus.wrapped = wrapped_q;
  assign bus.wr_ptr  = wr_ptr_q;
  assign bus.clkb    = sys_clk;
  assign bus.rstb    = 1'b0;
  assign bus.enb     = enb_q;
  assign bus.web     = web_q;
  assign bus.addrb   = addrb_q;
  assign bus.datab   = datab_q;

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// Directed bench for tdc_capture_ctrl with a 16-word buffer; a negedge monitor plays the BRAM.
module tb_tdc_capture_ctrl;

  localparam int ONES_W = 8;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   wcount = 0;
  logic [31:0] mem [16];

  always #5 clk = ~clk;

  tdc_capture_ctrl_if #(.ONES_W(ONES_W), .ADDR_W(ADDR_W)) bus ();

  tdc_capture_ctrl #(.ONES_W(ONES_W), .ADDR_W(ADDR_W)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  always @(negedge clk) begin
    if (bus.enb && bus.web == 4'hF) begin
      mem[bus.addrb[5:2]] = bus.datab;
      wcount = wcount + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nz;
    bus.ones = '0;
    bus.run = 1'b0;
    bus.clr = 1'b0;
    bus.ring_mode = 1'b0;
    bus.decim = 8'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 + 32'(i);

    // Reset state
    #1;
    chk("rst_rdy", 32'(bus.rdy), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_enb", 32'(bus.enb), 0);
    chk("rst_web", 32'(bus.web), 0);
    chk("rst_addrb", 32'(bus.addrb), 0);
    chk("rst_wr_ptr", 32'(bus.wr_ptr), 0);
    chk("rst_rstb", 32'(bus.rstb), 0);
    #21 rst_n = 1'b1;
    tick();
    chk("idle_rdy", 32'(bus.rdy), 1);

    // One-shot, decim=0, ramp 0..15
    wcount = 0;
    bus.run = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      bus.ones = 8'(k);
      tick();
      chk("os0_web", 32'(bus.web), 32'hF);
      chk("os0_addrb", 32'(bus.addrb), 32'(4 * k));
      chk("os0_datab", bus.datab, 32'(k));
      if (k == 0)  chk("os0_rdy_low", 32'(bus.rdy), 0);
      if (k == 14) chk("os0_full_pre", 32'(bus.full), 0);
      if (k == 15) chk("os0_full", 32'(bus.full), 1);
    end
    tick();
    chk("os0_done_web", 32'(bus.web), 0);
    chk("os0_done_rdy", 32'(bus.rdy), 0);
    chk("os0_wr_ptr", 32'(bus.wr_ptr), 60);
    chk("os0_wcount", 32'(wcount), 16);
    for (int i = 0; i < 16; i++) chk("os0_mem", mem[i], 32'(i));
    bus.run = 1'b0;
    tick();
    chk("os0_rdy_still_low", 32'(bus.rdy), 0);
    tick();
    chk("os0_rdy_back", 32'(bus.rdy), 1);
    chk("os0_full_hold", 32'(bus.full), 1);

    // One-shot, decim=2: strobes every 3rd RUN cycle, 46-cycle RUN
    wcount = 0;
    bus.decim = 8'd2;
    bus.run = 1'b1;
    tick();
    for (int c = 0; c < 49; c++) begin
      bus.ones = 8'(100 + c);
      tick();
      if (c % 3 == 0 && c <= 45) begin
        chk("d2_web_on", 32'(bus.web), 32'hF);
        chk("d2_addrb", 32'(bus.addrb), 32'(4 * (c / 3)));
      end else begin
        chk("d2_web_off", 32'(bus.web), 0);
      end
      if (c <= 45) chk("d2_datab", bus.datab, 32'(100 + 3 * (c / 3)));
      if (c == 44) chk("d2_full_pre", 32'(bus.full), 0);
      if (c == 45) chk("d2_full", 32'(bus.full), 1);
    end
    chk("d2_wcount", 32'(wcount), 16);
    chk("d2_mem15", mem[15], 32'(145));
    bus.run = 1'b0;
    bus.decim = 8'd0;
    tick();
    tick();
    chk("d2_rdy_back", 32'(bus.rdy), 1);

    // Ring mode, 40 samples then stop
    wcount = 0;
    bus.ring_mode = 1'b1;
    bus.run = 1'b1;
    tick();
    chk("ring_full_cleared", 32'(bus.full), 0);
    for (int k = 0; k < 40; k++) begin
      bus.ones = 8'(k);
      tick();
      chk("ring_web", 32'(bus.web), 32'hF);
      chk("ring_addrb", 32'(bus.addrb), 32'((4 * k) % 64));
      if (k == 14) chk("ring_wrapped_pre", 32'(bus.wrapped), 0);
      if (k == 15) chk("ring_wrapped", 32'(bus.wrapped), 1);
    end
    bus.run = 1'b0;
    bus.ring_mode = 1'b0;
    tick();
    chk("ring_stop_web", 32'(bus.web), 0);
    chk("ring_wr_ptr", 32'(bus.wr_ptr), 28);
    chk("ring_full", 32'(bus.full), 0);
    chk("ring_wrapped_hold", 32'(bus.wrapped), 1);
    chk("ring_wcount", 32'(wcount), 40);
    for (int i = 0; i < 8; i++) chk("ring_mem_new", mem[i], 32'(32 + i));
    chk("ring_mem8", mem[8], 32'(24));
    tick();
    tick();
    chk("ring_rdy_back", 32'(bus.rdy), 1);

    // One-shot aborted after 5 writes
    wcount = 0;
    bus.run = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      bus.ones = 8'(50 + k);
      tick();
      chk("ab_addrb", 32'(bus.addrb), 32'(4 * k));
    end
    chk("ab_wrapped_cleared", 32'(bus.wrapped), 0);
    bus.run = 1'b0;
    tick();
    chk("ab_web_off", 32'(bus.web), 0);
    tick();
    tick();
    chk("ab_wcount", 32'(wcount), 5);
    chk("ab_wr_ptr", 32'(bus.wr_ptr), 16);
    chk("ab_full", 32'(bus.full), 0);
    chk("ab_rdy_back", 32'(bus.rdy), 1);

    // run and clr together: clear wins
    wcount = 0;
    bus.run = 1'b1;
    bus.clr = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("clr_web", 32'(bus.web), 32'hF);
      chk("clr_addrb", 32'(bus.addrb), 32'(4 * k));
      chk("clr_datab", bus.datab, 0);
      chk("clr_full", 32'(bus.full), 1);
    end
    tick();
    chk("clr_done_full", 32'(bus.full), 0);
    chk("clr_done_web", 32'(bus.web), 0);
    chk("clr_done_rdy", 32'(bus.rdy), 0);
    chk("clr_wcount", 32'(wcount), 16);
    nz = 0;
    for (int i = 0; i < 16; i++) if (mem[i] != 0) nz++;
    chk("clr_mem_nonzero", 32'(nz), 0);
    bus.clr = 1'b0;
    tick();
    tick();
    chk("clr_rdy_back", 32'(bus.rdy), 1);

    // clr pulsed for 2 cycles still clears the whole buffer
    wcount = 0;
    bus.clr = 1'b1;
    tick();
    tick();
    bus.clr = 1'b0;
    chk("clrp_addrb0", 32'(bus.addrb), 0);
    for (int k = 1; k < 16; k++) tick();
    chk("clrp_last_addrb", 32'(bus.addrb), 60);
    chk("clrp_last_web", 32'(bus.web), 32'hF);
    tick();
    chk("clrp_wcount", 32'(wcount), 16);
    chk("clrp_full", 32'(bus.full), 0);
    tick();
    chk("clrp_rdy_back", 32'(bus.rdy), 1);

    // Async reset in the middle of a capture
    wcount = 0;
    bus.run = 1'b1;
    bus.ones = 8'hA5;
    tick();
    tick();
    tick();
    chk("ar_pre_web", 32'(bus.web), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("ar_enb", 32'(bus.enb), 0);
    chk("ar_web", 32'(bus.web), 0);
    chk("ar_addrb", 32'(bus.addrb), 0);
    chk("ar_datab", bus.datab, 0);
    chk("ar_wr_ptr", 32'(bus.wr_ptr), 0);
    chk("ar_rdy", 32'(bus.rdy), 0);
    bus.run = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    chk("ar_rdy_back", 32'(bus.rdy), 1);
    bus.ones = 8'h3C;
    bus.run = 1'b1;
    tick();
    tick();
    chk("ar_restart_addrb", 32'(bus.addrb), 0);
    chk("ar_restart_web", 32'(bus.web), 32'hF);
    chk("ar_restart_datab", bus.datab, 32'h3C);
    bus.run = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
